// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Data wins ties; every transaction is bounded by a TIMEOUT wait-cycle abort.
`default_nettype none

module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ImemReqF,
  input  logic [31:0] PCF,
  input  logic        FlushF,
  input  logic        DmemReqM,
  input  logic        DmemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [31:0] ReadDataM,
  output logic        DataValidM,
  output logic        StallMemF,
  output logic        StallMemM,
  output logic        MemErr
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          squash, squash_d;
  logic          timed_out;
  logic [31:0]   resp;

  logic          mem_req_d, mem_we_d;
  logic [31:0]   mem_addr_d, mem_wdata_d;
  logic [3:0]    mem_be_d;
  logic [31:0]   InstrF_d, ReadDataM_d;
  logic          InstrValidF_d, DataValidM_d, MemErr_d;

  assign StallMemM = DmemReqM & ~DataValidM;
  assign StallMemF = (ImemReqF & ~InstrValidF) | StallMemM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      squash      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_be      <= 4'h0;
      InstrF      <= 32'h0;
      InstrValidF <= 1'b0;
      ReadDataM   <= 32'h0;
      DataValidM  <= 1'b0;
      MemErr      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      squash      <= squash_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      mem_be      <= mem_be_d;
      InstrF      <= InstrF_d;
      InstrValidF <= InstrValidF_d;
      ReadDataM   <= ReadDataM_d;
      DataValidM  <= DataValidM_d;
      MemErr      <= MemErr_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    squash_d      = squash;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    mem_be_d      = mem_be;
    InstrF_d      = InstrF;
    InstrValidF_d = 1'b0;
    ReadDataM_d   = ReadDataM;
    DataValidM_d  = 1'b0;
    MemErr_d      = MemErr;
    cnt_inc       = cnt + CW'(1);
    timed_out     = (cnt_inc == TIMEOUT_C);
    // An aborted transaction returns zero data.
    resp          = mem_ready ? mem_rdata : 32'h0;

    case (state)
      IDLE: begin
        // A requester whose completion pulse is high this cycle is not re-granted.
        if (DmemReqM && !DataValidM) begin
          state_d     = DACC;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = DmemWriteM;
          mem_addr_d  = ALUResultM;
          mem_wdata_d = WriteDataM;
          mem_be_d    = DmemWriteM ? ByteEnM : 4'hF;
        end else if (ImemReqF && !InstrValidF) begin
          state_d    = IFETCH;
          cnt_d      = '0;
          squash_d   = FlushF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = PCF;
          mem_be_d   = 4'hF;
        end
      end
      IFETCH: begin
        if (mem_ready || timed_out) begin
          state_d   = IDLE;
          cnt_d     = '0;
          squash_d  = 1'b0;
          mem_req_d = 1'b0;
          if (!mem_ready) MemErr_d = 1'b1;
          if (!(squash || FlushF)) begin
            InstrF_d      = resp;
            InstrValidF_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (FlushF) squash_d = 1'b1;
        end
      end
      DACC: begin
        if (mem_ready || timed_out) begin
          state_d      = IDLE;
          cnt_d        = '0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          DataValidM_d = 1'b1;
          if (!mem_ready) MemErr_d = 1'b1;
          // A completed store leaves the last load data in place.
          if (!mem_we || !mem_ready) ReadDataM_d = resp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ImemReqF = 1'b0;
  logic [31:0] PCF = 32'h0;
  logic        FlushF = 1'b0;
  logic        DmemReqM = 1'b0;
  logic        DmemWriteM = 1'b0;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [3:0]  ByteEnM = 4'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] InstrF, ReadDataM;
  logic        InstrValidF, DataValidM, StallMemF, StallMemM, MemErr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ImemReqF(ImemReqF), .PCF(PCF), .FlushF(FlushF),
    .DmemReqM(DmemReqM), .DmemWriteM(DmemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .InstrF(InstrF), .InstrValidF(InstrValidF),
    .ReadDataM(ReadDataM), .DataValidM(DataValidM),
    .StallMemF(StallMemF), .StallMemM(StallMemM), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int guard;

    // Reset state
    #2;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_valids", {30'h0, InstrValidF, DataValidM}, 32'h0);
    chk("rst_data", InstrF | ReadDataM, 32'h0);
    chk("rst_memerr", {31'h0, MemErr}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Fetch at 0x100, ready three cycles after mem_req
    ImemReqF = 1'b1; PCF = 32'h100;
    #1 chk("f_stall_req", {31'h0, StallMemF}, 32'h1);
    step();
    chk("f_mem_req", {31'h0, mem_req}, 32'h1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", {28'h0, mem_be}, 32'hF);
    chk("f_mem_we", {31'h0, mem_we}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("f_wait_stall", {31'h0, StallMemF}, 32'h1);
      chk("f_wait_novalid", {31'h0, InstrValidF}, 32'h0);
      chk("f_wait_req", {31'h0, mem_req}, 32'h1);
      if (i < 2) step();
    end
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    step();
    chk("f_valid", {31'h0, InstrValidF}, 32'h1);
    chk("f_instr", InstrF, 32'h00500093);
    chk("f_req_low", {31'h0, mem_req}, 32'h0);
    chk("f_stall_clear", {31'h0, StallMemF}, 32'h0);
    ImemReqF = 1'b0; mem_ready = 1'b0;
    step();
    chk("f_valid_pulse", {31'h0, InstrValidF}, 32'h0);

    // Simultaneous fetch and load: data first
    ImemReqF = 1'b1; PCF = 32'h300;
    DmemReqM = 1'b1; DmemWriteM = 1'b0; ALUResultM = 32'h2000;
    #1 chk("p_stallm", {31'h0, StallMemM}, 32'h1);
    step();
    chk("p_addr_data", mem_addr, 32'h2000);
    chk("p_we_load", {31'h0, mem_we}, 32'h0);
    chk("p_be_load", {28'h0, mem_be}, 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("p_dvalid", {31'h0, DataValidM}, 32'h1);
    chk("p_rdata", ReadDataM, 32'hCAFEF00D);
    chk("p_stallm_clear", {31'h0, StallMemM}, 32'h0);
    chk("p_stallf_held", {31'h0, StallMemF}, 32'h1);
    mem_ready = 1'b0;
    step();
    DmemReqM = 1'b0;
    chk("p_fetch_grant", {31'h0, mem_req}, 32'h1);
    chk("p_fetch_addr", mem_addr, 32'h300);
    chk("p_dvalid_pulse", {31'h0, DataValidM}, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    step();
    chk("p_ivalid", {31'h0, InstrValidF}, 32'h1);
    chk("p_instr", InstrF, 32'h11111111);
    ImemReqF = 1'b0; mem_ready = 1'b0;
    step();

    // Store with partial byte enables
    DmemReqM = 1'b1; DmemWriteM = 1'b1; ALUResultM = 32'h2004;
    WriteDataM = 32'hDEADBEEF; ByteEnM = 4'b0011;
    step();
    chk("s_we", {31'h0, mem_we}, 32'h1);
    chk("s_be", {28'h0, mem_be}, 32'h3);
    chk("s_addr", mem_addr, 32'h2004);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    WriteDataM = 32'h0; ALUResultM = 32'h0; ByteEnM = 4'hF;
    step();
    chk("s_wdata_hold", mem_wdata, 32'hDEADBEEF);
    chk("s_be_hold", {28'h0, mem_be}, 32'h3);
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    step();
    chk("s_dvalid", {31'h0, DataValidM}, 32'h1);
    chk("s_rdata_kept", ReadDataM, 32'hCAFEF00D);
    DmemReqM = 1'b0; DmemWriteM = 1'b0; mem_ready = 1'b0;
    step();

    // Flush one cycle after fetch grant
    ImemReqF = 1'b1; PCF = 32'h400;
    step();
    chk("fl_req", {31'h0, mem_req}, 32'h1);
    FlushF = 1'b1;
    step();
    FlushF = 1'b0; PCF = 32'h800;
    mem_ready = 1'b1; mem_rdata = 32'h99999999;
    step();
    chk("fl_no_valid", {31'h0, InstrValidF}, 32'h0);
    chk("fl_instr_kept", InstrF, 32'h11111111);
    mem_ready = 1'b0;
    step();
    chk("fl_refetch_addr", mem_addr, 32'h800);
    chk("fl_refetch_req", {31'h0, mem_req}, 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'h00A00113;
    step();
    chk("fl_refetch_valid", {31'h0, InstrValidF}, 32'h1);
    chk("fl_refetch_instr", InstrF, 32'h00A00113);
    ImemReqF = 1'b0; mem_ready = 1'b0;
    step();

    // Timeout: memory never answers
    DmemReqM = 1'b1; DmemWriteM = 1'b0; ALUResultM = 32'h3000;
    step();
    n = 0; guard = 0;
    while (!DataValidM && guard < 400) begin
      if (mem_req) n++;
      guard++;
      step();
    end
    chk("to_wait_cycles", n, 32'd255);
    chk("to_dvalid", {31'h0, DataValidM}, 32'h1);
    chk("to_rdata_zero", ReadDataM, 32'h0);
    chk("to_memerr", {31'h0, MemErr}, 32'h1);
    chk("to_req_low", {31'h0, mem_req}, 32'h0);
    DmemReqM = 1'b0;
    step(); step();
    chk("to_memerr_sticky", {31'h0, MemErr}, 32'h1);

    // Reset mid data access
    DmemReqM = 1'b1; ALUResultM = 32'h4000;
    step();
    chk("r_req", {31'h0, mem_req}, 32'h1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("r_req_now", {31'h0, mem_req}, 32'h0);
    chk("r_addr_now", mem_addr, 32'h0);
    chk("r_be_now", {28'h0, mem_be}, 32'h0);
    chk("r_memerr_now", {31'h0, MemErr}, 32'h0);
    chk("r_data_now", InstrF | ReadDataM, 32'h0);
    DmemReqM = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_no_dvalid", {31'h0, DataValidM}, 32'h0);
      chk("r_idle_req", {31'h0, mem_req}, 32'h0);
    end
    chk("r_rdata_zero", ReadDataM, 32'h0);
    mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
